// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-128 decrypt round-key path.
// Round keys use an ascending [0:KW-1] range, so bit 0 is the key's leading bit.
package aes_dec_pkg;
    localparam int NR = 10;
    localparam int KW = 128;
    localparam int AW = 4;
    localparam logic [AW-1:0] RK_TOP = AW'(NR);

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        READY
    } state_t;

    typedef logic [0:KW-1] rkey_t;
endpackage

// File: rtl/rkey_store.sv
// (NR+1) x KW round-key array: one synchronous write port and an asynchronous read port.
// No reset: entries are only read after a complete burst has written them.
module rkey_store
    import aes_dec_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rkey_t         wdata,
    input  logic [AW-1:0] raddr,
    output rkey_t         rdata
);
    rkey_t mem [0:NR];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rkey_reverse_buf.sv
// Captures an 11-key forward burst and replays it in reverse (NR..0) for every block until a reload.
// Zero-latency output from rd_ptr; the input side has no backpressure, so in_rdy gates the expander upstream.
module rkey_reverse_buf
    import aes_dec_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [0:KW-1] rkey_in,
    input  logic          rkey_in_vld,
    input  logic          rkey_in_last,
    output logic          in_rdy,
    output logic [0:KW-1] rk_out,
    output logic          rk_out_vld,
    input  logic          rk_out_rdy,
    output logic          rk_out_first,
    output logic          rk_out_last,
    input  logic          reload_req,
    output logic          err
);
    state_t        state, state_nxt;
    logic [AW-1:0] wr_cnt, wr_cnt_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic          reload_pend, reload_pend_nxt;
    logic          err_nxt;
    logic          we;
    logic [AW-1:0] waddr;
    logic          at_boundary;
    logic          xfer;

    // A pending reload is applied at a sequence boundary; the key shown there is
    // withheld so no new decrypt sequence can start on the old schedule.
    assign at_boundary  = reload_pend && (rd_ptr == RK_TOP);
    assign rk_out_vld   = (state == READY) && !at_boundary;
    assign xfer         = rk_out_vld && rk_out_rdy;
    assign rk_out_first = rk_out_vld && (rd_ptr == RK_TOP);
    assign rk_out_last  = rk_out_vld && (rd_ptr == '0);
    assign in_rdy       = (state != READY);

    rkey_store u_store (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (rkey_in),
        .raddr (rd_ptr),
        .rdata (rk_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            wr_cnt      <= '0;
            rd_ptr      <= RK_TOP;
            reload_pend <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_cnt      <= wr_cnt_nxt;
            rd_ptr      <= rd_ptr_nxt;
            reload_pend <= reload_pend_nxt;
            err         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wr_cnt_nxt      = wr_cnt;
        rd_ptr_nxt      = rd_ptr;
        reload_pend_nxt = reload_pend;
        err_nxt         = err;
        we              = 1'b0;
        waddr           = wr_cnt;
        unique case (state)
            EMPTY: begin
                if (rkey_in_vld) begin
                    we    = 1'b1;
                    waddr = '0;
                    if (rkey_in_last) begin
                        err_nxt = 1'b1;
                    end else begin
                        wr_cnt_nxt = AW'(1);
                        state_nxt  = FILL;
                    end
                end
            end
            FILL: begin
                if (reload_req) reload_pend_nxt = 1'b1;
                if (!rkey_in_vld) begin
                    err_nxt         = 1'b1;
                    state_nxt       = EMPTY;
                    reload_pend_nxt = 1'b0;
                end else begin
                    we = 1'b1;
                    if (rkey_in_last && (wr_cnt == RK_TOP)) begin
                        rd_ptr_nxt = RK_TOP;
                        state_nxt  = READY;
                    end else if (rkey_in_last || (wr_cnt == RK_TOP)) begin
                        err_nxt         = 1'b1;
                        state_nxt       = EMPTY;
                        reload_pend_nxt = 1'b0;
                    end else begin
                        wr_cnt_nxt = wr_cnt + AW'(1);
                    end
                end
            end
            READY: begin
                if (reload_req)  reload_pend_nxt = 1'b1;
                if (rkey_in_vld) err_nxt = 1'b1;
                if (at_boundary) begin
                    state_nxt       = EMPTY;
                    reload_pend_nxt = 1'b0;
                end else if (xfer) begin
                    rd_ptr_nxt = (rd_ptr == '0) ? RK_TOP : rd_ptr - AW'(1);
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end
endmodule

// File: tb/tb_rkey_reverse_buf.sv
// Directed bench for rkey_reverse_buf using the FIPS-197 Appendix A.1 and C.1 key schedules.
module tb_rkey_reverse_buf;
    logic         clk = 1'b0;
    logic         rst;
    logic [0:127] rkey_in;
    logic         rkey_in_vld;
    logic         rkey_in_last;
    logic         in_rdy;
    logic [0:127] rk_out;
    logic         rk_out_vld;
    logic         rk_out_rdy;
    logic         rk_out_first;
    logic         rk_out_last;
    logic         reload_req;
    logic         err;

    int tests_run = 0;
    int fails = 0;

    logic [0:127] key_a [0:10];
    logic [0:127] key_b [0:10];

    always #5 clk = ~clk;

    rkey_reverse_buf dut (
        .clk          (clk),
        .rst          (rst),
        .rkey_in      (rkey_in),
        .rkey_in_vld  (rkey_in_vld),
        .rkey_in_last (rkey_in_last),
        .in_rdy       (in_rdy),
        .rk_out       (rk_out),
        .rk_out_vld   (rk_out_vld),
        .rk_out_rdy   (rk_out_rdy),
        .rk_out_first (rk_out_first),
        .rk_out_last  (rk_out_last),
        .reload_req   (reload_req),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_burst(input bit use_b, input int nbeats, input bit with_last);
        for (int i = 0; i < nbeats; i++) begin
            rkey_in      = use_b ? key_b[i] : key_a[i];
            rkey_in_vld  = 1'b1;
            rkey_in_last = with_last && (i == 10);
            tick();
        end
        rkey_in_vld  = 1'b0;
        rkey_in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if ({in_rdy, rk_out_vld, rk_out_first, rk_out_last, err} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_outputs: got rdy/vld/first/last/err=%b want 10000",
                     {in_rdy, rk_out_vld, rk_out_first, rk_out_last, err});
        end
    endtask

    task automatic test_fips_load();
        send_burst(1'b0, 11, 1'b1);
        tests_run++;
        if (rk_out !== key_a[10] || rk_out_vld !== 1'b1 || rk_out_first !== 1'b1 || in_rdy !== 1'b0) begin
            fails++;
            $display("FAIL fips_first: got key=%h vld=%b first=%b in_rdy=%b want key=%h vld=1 first=1 in_rdy=0",
                     rk_out, rk_out_vld, rk_out_first, in_rdy, key_a[10]);
        end
    endtask

    task automatic test_back_to_back();
        rk_out_rdy = 1'b1;
        for (int n = 0; n < 33; n++) begin
            tests_run++;
            if (rk_out !== key_a[10 - (n % 11)] || rk_out_vld !== 1'b1 ||
                rk_out_first !== ((n % 11) == 0) || rk_out_last !== ((n % 11) == 10)) begin
                fails++;
                $display("FAIL b2b_beat%0d: got key=%h vld=%b first=%b last=%b want key=%h vld=1 first=%b last=%b",
                         n, rk_out, rk_out_vld, rk_out_first, rk_out_last, key_a[10 - (n % 11)],
                         (n % 11) == 0, (n % 11) == 10);
            end
            tick();
        end
        rk_out_rdy = 1'b0;
        tests_run++;
        if (err !== 1'b0 || rk_out !== key_a[10] || rk_out_first !== 1'b1) begin
            fails++;
            $display("FAIL b2b_wrap: got err=%b key=%h first=%b want err=0 key=%h first=1",
                     err, rk_out, rk_out_first, key_a[10]);
        end
    endtask

    task automatic test_random_stall();
        int accepted = 0;
        int cycles = 0;
        bit r;
        while (accepted < 11 && cycles < 300) begin
            r = 1'($urandom_range(0, 1));
            rk_out_rdy = r;
            tests_run++;
            if (rk_out !== key_a[10 - accepted] || rk_out_vld !== 1'b1) begin
                fails++;
                $display("FAIL stall_cycle%0d: got key=%h vld=%b want key=%h vld=1",
                         cycles, rk_out, rk_out_vld, key_a[10 - accepted]);
            end
            tick();
            if (r) accepted++;
            cycles++;
        end
        rk_out_rdy = 1'b0;
        tests_run++;
        if (accepted != 11) begin
            fails++;
            $display("FAIL stall_timeout: got %0d keys accepted want 11", accepted);
        end
    endtask

    task automatic test_reload();
        rk_out_rdy = 1'b1;
        for (int n = 0; n < 11; n++) begin
            reload_req = (n == 3);
            tests_run++;
            if (rk_out !== key_a[10 - n] || rk_out_vld !== 1'b1) begin
                fails++;
                $display("FAIL reload_serve%0d: got key=%h vld=%b want key=%h vld=1",
                         n, rk_out, rk_out_vld, key_a[10 - n]);
            end
            tick();
        end
        reload_req = 1'b0;
        tests_run++;
        if (rk_out_vld !== 1'b0 || rk_out_first !== 1'b0) begin
            fails++;
            $display("FAIL reload_boundary: got vld=%b first=%b want vld=0 first=0", rk_out_vld, rk_out_first);
        end
        tick();
        rk_out_rdy = 1'b0;
        tests_run++;
        if (in_rdy !== 1'b1 || rk_out_vld !== 1'b0) begin
            fails++;
            $display("FAIL reload_empty: got in_rdy=%b vld=%b want in_rdy=1 vld=0", in_rdy, rk_out_vld);
        end
        send_burst(1'b1, 11, 1'b1);
        tests_run++;
        if (rk_out !== key_b[10] || rk_out_first !== 1'b1 || rk_out_vld !== 1'b1) begin
            fails++;
            $display("FAIL newkey_first: got key=%h first=%b vld=%b want key=%h first=1 vld=1",
                     rk_out, rk_out_first, rk_out_vld, key_b[10]);
        end
        rk_out_rdy = 1'b1;
        for (int n = 0; n < 11; n++) begin
            tests_run++;
            if (rk_out !== key_b[10 - n] || rk_out_last !== (n == 10)) begin
                fails++;
                $display("FAIL newkey_serve%0d: got key=%h last=%b want key=%h last=%b",
                         n, rk_out, rk_out_last, key_b[10 - n], n == 10);
            end
            tick();
        end
        rk_out_rdy = 1'b0;
        // Reload requested while idling at the sequence boundary.
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        tests_run++;
        if (rk_out_vld !== 1'b0) begin
            fails++;
            $display("FAIL idle_reload_vld: got vld=%b want 0", rk_out_vld);
        end
        tick();
        tests_run++;
        if (in_rdy !== 1'b1) begin
            fails++;
            $display("FAIL idle_reload_empty: got in_rdy=%b want 1", in_rdy);
        end
    endtask

    task automatic test_gap();
        send_burst(1'b0, 5, 1'b0);
        tick();
        tests_run++;
        if (err !== 1'b1 || in_rdy !== 1'b1 || rk_out_vld !== 1'b0) begin
            fails++;
            $display("FAIL gap_err: got err=%b in_rdy=%b vld=%b want err=1 in_rdy=1 vld=0",
                     err, in_rdy, rk_out_vld);
        end
        send_burst(1'b0, 11, 1'b1);
        tests_run++;
        if (rk_out !== key_a[10] || rk_out_vld !== 1'b1 || err !== 1'b1) begin
            fails++;
            $display("FAIL gap_reload: got key=%h vld=%b err=%b want key=%h vld=1 err=1",
                     rk_out, rk_out_vld, err, key_a[10]);
        end
    endtask

    task automatic test_rst_mid_fill();
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        tick();
        send_burst(1'b0, 6, 1'b0);
        rkey_in     = key_a[6];
        rkey_in_vld = 1'b1;
        rst         = 1'b1;
        tick();
        rst         = 1'b0;
        rkey_in_vld = 1'b0;
        tests_run++;
        if (in_rdy !== 1'b1 || rk_out_vld !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL rst_fill: got in_rdy=%b vld=%b err=%b want in_rdy=1 vld=0 err=0",
                     in_rdy, rk_out_vld, err);
        end
        send_burst(1'b1, 11, 1'b1);
        tests_run++;
        if (rk_out !== key_b[10] || err !== 1'b0) begin
            fails++;
            $display("FAIL rst_reload: got key=%h err=%b want key=%h err=0", rk_out, err, key_b[10]);
        end
    endtask

    task automatic test_ready_overrun();
        rkey_in     = key_a[0];
        rkey_in_vld = 1'b1;
        tick();
        rkey_in_vld = 1'b0;
        tests_run++;
        if (err !== 1'b1 || rk_out !== key_b[10] || rk_out_vld !== 1'b1) begin
            fails++;
            $display("FAIL overrun: got err=%b key=%h vld=%b want err=1 key=%h vld=1",
                     err, rk_out, rk_out_vld, key_b[10]);
        end
    endtask

    initial begin
        key_a[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        key_a[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        key_a[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        key_a[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        key_a[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        key_a[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        key_a[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        key_a[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        key_a[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        key_a[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        key_a[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        key_b[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_b[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        key_b[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        key_b[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        key_b[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        key_b[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        key_b[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        key_b[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        key_b[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        key_b[9]  = 128'hac7766f319fadc2128d12941575c006e;
        key_b[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst          = 1'b1;
        rkey_in      = '0;
        rkey_in_vld  = 1'b0;
        rkey_in_last = 1'b0;
        rk_out_rdy   = 1'b0;
        reload_req   = 1'b0;

        test_reset();
        test_fips_load();
        test_back_to_back();
        test_random_stall();
        test_reload();
        test_gap();
        test_rst_mid_fill();
        test_ready_overrun();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/rkey_reverse_buf.md
Name: rkey_reverse_buf

Overview:
Consumer-side end of the round-key stream produced by the 128-bit key expander. It captures the 11 forward-order round keys (0..10) in one burst. It then serves them in reverse order (10 down to 0) to the decryption round datapath through a valid/ready handshake. The stored schedule is replayed for every block until a new key is requested, so one expansion serves many ciphertext blocks.

Parameters:
NR, 10, number of AES rounds; storage depth is NR+1 (AES-128 only)
KW, 128, round-key width in bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rkey_in  in  [0:KW-1]  round key from key expander
rkey_in_vld  in  1  one round key transferred this cycle (expander has no backpressure)
rkey_in_last  in  1  marks round key NR (final beat of burst)
in_rdy  out  1  buffer accepts a key burst; integrator gates expander kt_vld with this
rk_out  out  [0:KW-1]  round key for current decrypt round
rk_out_vld  out  1  rk_out valid
rk_out_rdy  in  1  datapath consumes rk_out this cycle
rk_out_first  out  1  rk_out is round key NR (first of a decrypt sequence)
rk_out_last  out  1  rk_out is round key 0 (last of a decrypt sequence)
reload_req  in  1  pulse: discard schedule, accept a new key after current sequence
err  out  1  sticky protocol error flag, cleared only by rst

Behaviour:
- Reset values: state EMPTY, wr_cnt=0, rd_ptr=NR, reload_pend=0, err=0. Outputs: in_rdy=1, rk_out_vld=0, rk_out_first=0, rk_out_last=0. Storage contents undefined and never read before FILL completes.
- States:
  EMPTY: in_rdy=1. On rkey_in_vld, write mem[0], wr_cnt=1, go to FILL.
  FILL: in_rdy=1. Every rkey_in_vld writes mem[wr_cnt] and increments wr_cnt.
  - rkey_in_last with wr_cnt==NR: write mem[NR], rd_ptr=NR, go to READY.
  - rkey_in_last with wr_cnt!=NR, or wr_cnt reaching NR+1 without last: set err, go to EMPTY.
  - A cycle without rkey_in_vld while in FILL is a gap: set err, go to EMPTY (the expander never gaps mid-burst).
  READY: in_rdy=0, rk_out_vld=1, rk_out=mem[rd_ptr] (combinational read, zero latency from rd_ptr).
  - rk_out_first=(rd_ptr==NR). rk_out_last=(rd_ptr==0).
  - On rk_out_vld&rk_out_rdy: rd_ptr decrements. From 0 it wraps to NR.
  - rkey_in_vld in READY: ignored, sets err.
- reload_req: sets reload_pend in any state except EMPTY. reload_req in EMPTY is a no-op.
  - In READY with reload_pend=1 and rd_ptr==NR (sequence boundary, including the cycle right after a wrap): go to EMPTY, rk_out_vld drops next cycle, reload_pend clears.
  - A reload_req arriving mid-sequence waits until key 0 is consumed. An in-flight block always completes with the old schedule.
  - reload_req in the same cycle as the transfer of key 0: honoured at the wrap, so no new sequence starts.
- reload_req during FILL: reload_pend set. Applied on entry to READY at rd_ptr==NR, i.e. immediate return to EMPTY (burst discarded).
- Simultaneous reload_req and a protocol error in FILL: error takes effect and reload_pend clears.
- rst mid-FILL or mid-READY: state returns to EMPTY next cycle. The expander shares rst.
- rk_out_rdy while rk_out_vld=0: ignored.

Decomposition:
- Package aes_dec_pkg holds NR, KW, the state enum {EMPTY, FILL, READY} and the round-key typedef logic [0:KW-1].
- One sub-module, rkey_store: an (NR+1)xKW storage array with single write port and asynchronous read, suitable for distributed RAM.
- FSM, counters and handshake logic live in the top.

Test Plan:
- FIPS-197 key 000102030405060708090a0b0c0d0e0f through the expander -> after 11 beats, rk_out=13111d7fe3944a17f307a78b4d2b30c5 with rk_out_first=1. The 11th served key is 000102030405060708090a0b0c0d0e0f with rk_out_last=1.
- rk_out_rdy held high for 33 cycles -> three identical 11-key sequences, rd_ptr wraps 0->10 with no bubble, err=0.
- rk_out_rdy toggled 1/0 randomly -> rk_out stable while not accepted, and the key order is unchanged.
- reload_req at the 4th served key -> keys 6..0 still served, then in_rdy=1 and rk_out_vld=0. A new key 2b7e151628aed2a6abf7158809cf4f3c yields first key d014f9a8c9ee2589e13f0cc8b6630ca6.
- Burst with rkey_in_vld dropped after beat 5 -> err=1, state EMPTY, in_rdy=1. A following clean burst loads correctly and err stays 1.
- rst asserted during beat 7 of FILL -> next cycle in_rdy=1, rk_out_vld=0, err=0.
